multi_channel_rate_sync: RTL

MULTI_CHANNEL_RATE_SYNC -- requirements
Module: multi_channel_rate_sync

---
 rtl/multi_channel_rate_sync.sv | 111 +++++++++++
 1 files changed

// File: rtl/multi_channel_rate_sync.sv
// Purpose : moves per-channel samples from the clk domain onto the rising edges of an asynchronous slow clock.
// Latency : slow_tick and out_valid SYNC_STAGES+1 clk cycles after the first clk edge that samples slow_clk_async high.
// Backpres: none; a channel holds one sample, and a further sample before the next tick counts as a drop.
//
// Ports:
//   clk, reset          - sole clock; asynchronous active-high reset
//   slow_clk_async      - slow-rate clock, sampled as data through a SYNC_STAGES synchroniser
//   in_valid / in_data  - per-channel sample strobe and packed samples (channel i at [i*DATA_WIDTH +: DATA_WIDTH])
//   ovf_clear           - clears overrun and drop_count on every channel
//   slow_tick           - one-cycle pulse per detected slow_clk_async rising edge
//   out_data / out_valid- transferred samples (same packing) and per-channel one-cycle valid
//   overrun / drop_count- sticky drop flag and saturating 8-bit drop count per channel
module multi_channel_rate_sync #(
  parameter int DATA_WIDTH  = 24,
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_MODE   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         slow_clk_async,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic                         ovf_clear,
  output logic                         slow_tick,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]            out_valid,
  output logic [NUM_CH-1:0]            overrun,
  output logic [NUM_CH*8-1:0]          drop_count
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  // Registered edge detect. This is the internal tick event: the cycle in which
  // rise_q is high is the transfer cycle, so the output registers and slow_tick
  // all update together on the following edge.
  logic                   rise_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
      rise_q    <= 1'b0;
      slow_tick <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], slow_clk_async};
      sync_prev <= sync_q[SYNC_STAGES-1];
      rise_q    <= sync_q[SYNC_STAGES-1] & ~sync_prev;
      slow_tick <= rise_q;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] din;
    logic                  pend_q;
    logic                  vld_q;
    logic                  ovr_q;
    logic [7:0]            cnt_q;
    logic                  drop;

    assign din  = in_data[ch*DATA_WIDTH +: DATA_WIDTH];
    // A transfer frees the slot in the same cycle, so a sample arriving on the
    // tick is never a drop.
    assign drop = in_valid[ch] & pend_q & ~rise_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hold_q <= '0;
        out_q  <= '0;
        pend_q <= 1'b0;
        vld_q  <= 1'b0;
        ovr_q  <= 1'b0;
        cnt_q  <= '0;
      end else begin
        vld_q <= rise_q & pend_q;
        if (rise_q && pend_q) begin
          out_q <= hold_q;
        end

        if (in_valid[ch]) begin
          // Oldest-kept mode only refuses the new sample when it would be a drop.
          if (!pend_q || rise_q || (HOLD_MODE == 0)) begin
            hold_q <= din;
          end
          pend_q <= 1'b1;
        end else if (rise_q) begin
          pend_q <= 1'b0;
        end

        // A drop in the clearing cycle wins over the clear.
        if (ovf_clear) begin
          ovr_q <= drop;
          cnt_q <= {7'd0, drop};
        end else if (drop) begin
          ovr_q <= 1'b1;
          if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
      end
    end

    assign out_data[ch*DATA_WIDTH +: DATA_WIDTH] = out_q;
    assign out_valid[ch]                         = vld_q;
    assign overrun[ch]                           = ovr_q;
    assign drop_count[ch*8 +: 8]                 = cnt_q;
  end

endmodule
